// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants, defaults and FSM state type for the multi-port register file
package regfile_mp_pkg;
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam int   RegNumLog2  = 5;
  localparam int   RegWidth    = 32;
  localparam logic [RegWidth-1:0] ZeroWord = '0;
  typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: per-register pending scoreboard with set-over-clear priority and per-port busy lookup
// Ports: clk/rst; en_i (file usable); clr_i (one-hot-per-register accepted writes);
//        set_i/set_addr_i (issue marks destination); re_i/raddr_i/hit_i (read ports, same-cycle write hit);
//        rbusy_o (per read port pending flag)
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = RegNumLog2,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [2**ADDR_W-1:0]     clr_i,
  input  logic                     set_i,
  input  logic [ADDR_W-1:0]        set_addr_i,
  input  logic [NUM_RD-1:0]        re_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  input  logic [NUM_RD-1:0]        hit_i,
  output logic [NUM_RD-1:0]        rbusy_o
);
  logic [2**ADDR_W-1:0] busy_q, busy_d;
  // set applied after clear: a younger issue supersedes an older write to the same register
  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (en_i && set_i && !(ZERO_REG && set_addr_i == '0)) busy_d[set_addr_i] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) busy_q <= '0;
    else busy_q <= busy_d;
  // a same-cycle write is bypassed to the reader, so the value is already valid
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rb
    assign rbusy_o[i] = en_i && re_i[i] == ReadEnable && busy_q[raddr_i[i*ADDR_W +: ADDR_W]] && !hit_i[i];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised N-read/M-write register file with init sweep, write bypass and RAW scoreboard
// Ports: clk/rst (async active-high); init_done (storage cleared);
//        we/waddr/wdata (write ports, port k packed at k*W); re/raddr/rdata (combinational read ports);
//        rbusy (read register pending); sb_set/sb_addr (mark destination pending)
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RegWidth,
  parameter int ADDR_W   = RegNumLog2,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);
  localparam int DEPTH = 2**ADDR_W;
  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [NUM_WR-1:0]   wacc;
  logic [DEPTH-1:0]    wclr;
  logic [NUM_RD-1:0]   hit;
  // counter parks at the top address so a single sweep is ever performed per reset
  always_ff @(posedge clk or posedge rst)
    if (rst == RstEnable) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else if (state_q == CLEAR) begin
      if (&cnt_q) begin
        state_q   <= RUN;
        init_done <= 1'b1;
      end else cnt_q <= cnt_q + 1'b1;
    end
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wacc[k] = init_done && we[k] == WriteEnable && !(ZERO_REG && waddr[k*ADDR_W +: ADDR_W] == '0);
  end
  // ascending port order makes the highest-index port win on an address collision
  always_ff @(posedge clk)
    if (!init_done) mem_q[cnt_q] <= DATA_W'(ZeroWord);
    else
      for (int k = 0; k < NUM_WR; k++)
        if (wacc[k]) mem_q[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
  always_comb begin
    wclr = '0;
    for (int k = 0; k < NUM_WR; k++)
      if (wacc[k]) wclr[waddr[k*ADDR_W +: ADDR_W]] = 1'b1;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] byp;
    logic              h;
    assign ra = raddr[i*ADDR_W +: ADDR_W];
    always_comb begin
      h   = 1'b0;
      byp = mem_q[ra];
      for (int k = 0; k < NUM_WR; k++)
        if (wacc[k] && waddr[k*ADDR_W +: ADDR_W] == ra) begin
          h   = 1'b1;
          byp = wdata[k*DATA_W +: DATA_W];
        end
    end
    assign hit[i] = h;
    assign rdata[i*DATA_W +: DATA_W] = (init_done && re[i] == ReadEnable && !(ZERO_REG && ra == '0)) ? byp : '0;
  end
  regfile_sb #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (init_done),
    .clr_i      (wclr),
    .set_i      (sb_set),
    .set_addr_i (sb_addr),
    .re_i       (re),
    .raddr_i    (raddr),
    .hit_i      (hit),
    .rbusy_o    (rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks a default file and a wide 4R/2W file without zero register against a register-array model
module tb_regfile_mp;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [1:0]   a_we = 0, a_re = 0, a_rbusy;
  logic [9:0]   a_waddr = 0, a_raddr = 0;
  logic [63:0]  a_wdata = 0, a_rdata;
  logic         a_sb_set = 0, a_done;
  logic [4:0]   a_sb_addr = 0;
  logic [1:0]   b_we = 0;
  logic [3:0]   b_re = 0, b_rbusy;
  logic [11:0]  b_waddr = 0;
  logic [23:0]  b_raddr = 0;
  logic [127:0] b_wdata = 0;
  logic [255:0] b_rdata;
  logic         b_sb_set = 0, b_done;
  logic [5:0]   b_sb_addr = 0;
  int nchk = 0, nfail = 0;

  regfile_mp dut_a (
    .clk(clk), .rst(rst), .init_done(a_done), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy), .sb_set(a_sb_set), .sb_addr(a_sb_addr));
  regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .init_done(b_done), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy), .sb_set(b_sb_set), .sb_addr(b_sb_addr));

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // model: cycles since reset release, register contents and pending flags per configuration
  logic [63:0] mm [2][64];
  bit          bz [2][64];
  int          cyc [2];

  function automatic int depth(int c); return c == 0 ? 32 : 64; endfunction
  function automatic bit zr(int c); return c == 0; endfunction
  function automatic int nrd(int c); return c == 0 ? 2 : 4; endfunction
  function automatic bit done(int c); return cyc[c] >= depth(c); endfunction
  function automatic bit wen(int c, int k); return c == 0 ? a_we[k] : b_we[k]; endfunction
  function automatic int wa(int c, int k); return c == 0 ? int'(a_waddr[k*5 +: 5]) : int'(b_waddr[k*6 +: 6]); endfunction
  function automatic logic [63:0] wd(int c, int k); return c == 0 ? 64'(a_wdata[k*32 +: 32]) : b_wdata[k*64 +: 64]; endfunction
  function automatic bit ren(int c, int i); return c == 0 ? a_re[i] : b_re[i]; endfunction
  function automatic int ra(int c, int i); return c == 0 ? int'(a_raddr[i*5 +: 5]) : int'(b_raddr[i*6 +: 6]); endfunction
  function automatic bit sbs(int c); return c == 0 ? a_sb_set : b_sb_set; endfunction
  function automatic int sba(int c); return c == 0 ? int'(a_sb_addr) : int'(b_sb_addr); endfunction
  function automatic logic [63:0] act_rd(int c, int i); return c == 0 ? 64'(a_rdata[i*32 +: 32]) : b_rdata[i*64 +: 64]; endfunction
  function automatic logic act_rb(int c, int i); return c == 0 ? a_rbusy[i] : b_rbusy[i]; endfunction
  function automatic logic act_done(int c); return c == 0 ? a_done : b_done; endfunction
  function automatic bit acc(int c, int k); return done(c) && wen(c, k) && !(zr(c) && wa(c, k) == 0); endfunction

  function automatic bit wr_hit(int c, int a);
    for (int k = 0; k < 2; k++) if (acc(c, k) && wa(c, k) == a) return 1;
    return 0;
  endfunction
  function automatic logic [63:0] exp_rd(int c, int i);
    logic [63:0] v;
    int a = ra(c, i);
    if (!done(c) || !ren(c, i) || (zr(c) && a == 0)) return 0;
    v = mm[c][a];
    for (int k = 0; k < 2; k++) if (acc(c, k) && wa(c, k) == a) v = wd(c, k);
    return v;
  endfunction
  function automatic logic exp_rb(int c, int i);
    return done(c) && ren(c, i) && bz[c][ra(c, i)] && !wr_hit(c, ra(c, i));
  endfunction

  always @(posedge clk or posedge rst)
    for (int c = 0; c < 2; c++)
      if (rst) begin
        cyc[c] = 0;
        for (int r = 0; r < 64; r++) bz[c][r] = 0;
      end else if (!done(c)) begin
        cyc[c]++;
        if (done(c)) for (int r = 0; r < 64; r++) mm[c][r] = 0;
      end else begin
        for (int k = 0; k < 2; k++)
          if (acc(c, k)) begin
            mm[c][wa(c, k)] = wd(c, k);
            bz[c][wa(c, k)] = 0;
          end
        if (sbs(c) && !(zr(c) && sba(c) == 0)) bz[c][sba(c)] = 1;
      end

  always @(negedge clk)
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("cfg%0d init_done", c), 64'(act_done(c)), 64'(done(c)));
      for (int i = 0; i < nrd(c); i++) begin
        chk($sformatf("cfg%0d rdata%0d", c, i), act_rd(c, i), exp_rd(c, i));
        chk($sformatf("cfg%0d rbusy%0d", c, i), 64'(act_rb(c, i)), 64'(exp_rb(c, i)));
      end
    end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic mid; @(negedge clk); #1; endtask

  initial begin
    repeat (3) tick;
    rst = 0;
    // writes, issues and reads during the sweep must all be ignored
    a_we = 2'b11; a_waddr = {5'd6, 5'd5}; a_wdata = {32'h66666666, 32'h55555555};
    a_sb_set = 1; a_sb_addr = 5'd9; a_re = 2'b01; a_raddr = {5'd9, 5'd5};
    b_we = 2'b01; b_waddr = {6'd0, 6'd40}; b_wdata = {64'h0, 64'h0123456789ABCDEF}; b_sb_set = 1; b_sb_addr = 6'd40;
    repeat (3) tick;
    mid; chk("sweep read r5", 64'(a_rdata[31:0]), 64'h0);
    tick; tick;
    a_we = 0; a_sb_set = 0; b_we = 0; b_sb_set = 0;
    repeat (26) tick;
    mid; chk("a done at 31", 64'(a_done), 64'h0);
    tick;
    mid; chk("a done at 32", 64'(a_done), 64'h1);
    repeat (31) tick;
    mid; chk("b done at 63", 64'(b_done), 64'h0);
    tick;
    mid; chk("b done at 64", 64'(b_done), 64'h1);
    a_re = 2'b11; b_re = 4'hF;
    for (int r = 0; r < 64; r++) begin
      a_raddr = {5'(r), 5'(r)}; b_raddr = {4{6'(r)}};
      mid; tick;
    end
    b_raddr = {4{6'd40}};
    mid; chk("b r40 after sweep", b_rdata[63:0], 64'h0);
    // contention on r3
    a_we = 2'b11; a_waddr = {5'd3, 5'd3}; a_wdata = {32'h22222222, 32'h11111111}; a_raddr = {5'd3, 5'd3};
    mid; chk("contention bypass", 64'(a_rdata[31:0]), 64'h22222222);
    tick; a_we = 0;
    mid; chk("contention stored", 64'(a_rdata[63:32]), 64'h22222222);
    tick;
    // zero register
    a_we = 2'b01; a_waddr = 0; a_wdata = {32'h0, 32'hDEADBEEF}; a_raddr = 0;
    b_we = 2'b01; b_waddr = 0; b_wdata = {64'h0, 64'hDEADBEEF}; b_raddr = 0;
    mid; chk("b r0 bypass", b_rdata[63:0], 64'hDEADBEEF);
    tick; a_we = 0; b_we = 0;
    mid; chk("a r0 zero", 64'(a_rdata[31:0]), 64'h0);
    chk("b r0 stored", b_rdata[127:64], 64'hDEADBEEF);
    tick;
    // scoreboard on r7
    a_re = 2'b10; a_raddr = {5'd7, 5'd0}; a_sb_set = 1; a_sb_addr = 5'd7;
    mid; chk("sb before edge", 64'(a_rbusy[1]), 64'h0);
    tick; a_sb_set = 0;
    mid; chk("sb busy", 64'(a_rbusy[1]), 64'h1);
    a_we = 2'b01; a_waddr = {5'd0, 5'd7}; a_wdata = {32'h0, 32'h0000ABCD};
    mid; chk("sb wb bypass busy", 64'(a_rbusy[1]), 64'h0);
    chk("sb wb bypass data", 64'(a_rdata[63:32]), 64'h0000ABCD);
    tick; a_we = 0;
    mid; chk("sb cleared", 64'(a_rbusy[1]), 64'h0);
    a_we = 2'b10; a_waddr = {5'd7, 5'd0}; a_wdata = {32'h5555, 32'h0}; a_sb_set = 1;
    tick; a_we = 0; a_sb_set = 0;
    mid; chk("sb set wins", 64'(a_rbusy[1]), 64'h1);
    chk("sb set wins data", 64'(a_rdata[63:32]), 64'h5555);
    a_sb_set = 1; a_sb_addr = 0;
    tick; a_sb_set = 0; a_raddr = {5'd0, 5'd0};
    mid; chk("sb r0 never busy", 64'(a_rbusy[1]), 64'h0);
    b_sb_set = 1; b_sb_addr = 6'd0; b_raddr = {4{6'd0}};
    tick; b_sb_set = 0;
    mid; chk("b sb r0 busy", 64'(b_rbusy[3]), 64'h1);
    // reset mid-sweep with r7 pending
    a_raddr = {5'd7, 5'd7};
    rst = 1; tick; rst = 0;
    repeat (10) tick;
    rst = 1;
    mid; chk("mid-sweep rst done", 64'(a_done), 64'h0);
    tick; rst = 0;
    repeat (31) tick;
    mid; chk("resweep done at 31", 64'(a_done), 64'h0);
    tick;
    mid; chk("resweep done at 32", 64'(a_done), 64'h1);
    chk("r7 busy cleared", 64'(a_rbusy[1]), 64'h0);
    chk("r7 zeroed", 64'(a_rdata[63:32]), 64'h0);
    repeat (32) tick;
    // random traffic on a small address window to provoke collisions and bypasses
    for (int n = 0; n < 400; n++) begin
      a_we = 2'($urandom); a_re = 2'($urandom);
      a_waddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      a_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      a_wdata = {32'($urandom), 32'($urandom)};
      a_sb_set = 1'($urandom); a_sb_addr = 5'($urandom_range(0, 7));
      b_we = 2'($urandom); b_re = 4'($urandom);
      b_waddr = {6'($urandom_range(0, 9)), 6'($urandom_range(0, 9))};
      b_raddr = {6'($urandom_range(0, 9)), 6'($urandom_range(0, 9)), 6'($urandom_range(0, 9)), 6'($urandom_range(0, 9))};
      b_wdata = {$urandom, $urandom, $urandom, $urandom};
      b_sb_set = 1'($urandom); b_sb_addr = 6'($urandom_range(0, 9));
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the next-generation core. It generalises the 2-read/1-write GPR file to N read and M write ports, with configurable width and depth. Storage is cleared after reset by a sequential init sweep. A per-register pending scoreboard lets decode detect RAW hazards on in-flight destinations. It sits between ID (read ports, scoreboard set) and WB (write ports).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- init_done  out  1  storage cleared, file usable
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, packed as waddr
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses
- rdata  out  NUM_RD*DATA_W  read data
- rbusy  out  NUM_RD  read register pending (scoreboard)
- sb_set  in  1  mark sb_addr pending (instruction issued)
- sb_addr  in  ADDR_W  destination to mark

## Operation
- FSM states are CLEAR and RUN. rst forces CLEAR, clear counter = 0, init_done = 0, all busy bits = 0.
- CLEAR: one register per cycle is written with 0 at the counter address. At counter = 2**ADDR_W-1 the FSM goes to RUN and init_done becomes 1 on the next edge.
- In CLEAR, we, sb_set and re are ignored; rdata = 0 and rbusy = 0.
- rst asserted mid-sweep or in RUN restarts CLEAR from address 0.
- Write, in RUN: each port k with we[k] writes wdata[k] to waddr[k] at the edge.
  - Address 0 is dropped when ZERO_REG=1.
  - Several ports writing the same address in one cycle: the highest-index port wins.
- Read port i, evaluated in priority order:
  - not init_done, or re[i]=0: rdata = 0.
  - raddr = 0 with ZERO_REG=1: rdata = 0.
  - Otherwise, if any write port hits raddr this cycle, rdata = wdata of the highest-index matching port (bypass).
  - Otherwise, rdata = stored value.
- Scoreboard: one busy bit per register, register 0 never busy when ZERO_REG=1.
  - Any accepted write to address a clears busy[a].
  - sb_set sets busy[sb_addr].
  - Set and clear on the same address in the same cycle: set wins, because the younger issue supersedes the older write.
- rbusy[i] = re[i] & busy[raddr[i]] & no accepted write to raddr[i] this cycle, since the bypassed value is valid.

## Timing
- Read and rbusy are combinational, 0-cycle latency. Write and scoreboard update take effect at the next rising edge.
- The init sweep takes 2**ADDR_W cycles; init_done rises on the edge after address 2**ADDR_W-1 is written, i.e. 32 cycles after rst release for ADDR_W=5.
- Reset values: init_done = 0, busy = all 0, clear counter = 0, rdata = 0, rbusy = 0. The storage array has no reset; it is zeroed by the sweep.
- Counter wrap: the counter stops at the top address and does not wrap into a second sweep.

## Structure
- Shared constants go in macros.v alongside the existing ones: `RstEnable`, `WriteEnable`, `ReadEnable`, `ZeroWord`.
- Add `RegNumLog2`-style defaults for ADDR_W and DATA_W.
- Sub-module regfile_sb: busy-bit array, set/clear priority, and the per-port rbusy lookup.
- The top level holds the FSM, counter, storage, write arbitration and bypass muxes, implemented as generate loops over NUM_RD and NUM_WR.

## Test plan
- Reset release with defaults: init_done = 0 for 32 cycles, then 1. During the sweep, re=1 raddr=5 gives rdata = 0. After the sweep, every register reads 0.
- Write contention: port0 writes r3 = 0x11111111 and port1 writes r3 = 0x22222222 in the same cycle. Same-cycle read of r3 returns 0x22222222, and the next cycle also reads 0x22222222.
- Zero register: we to r0 with 0xDEADBEEF, then reading r0 gives 0. Repeat with ZERO_REG=0: r0 reads 0xDEADBEEF.
- Scoreboard: sb_set on r7, next cycle rbusy for r7 = 1. A WB write to r7 gives rbusy = 0 in that same cycle and rdata = the bypassed value. sb_set and a write to r7 in the same cycle leave r7 busy.
- Reset mid-sweep at cycle 10 with busy bits set: init_done stays 0, the sweep restarts, and takes the full 32 cycles from the deassertion of rst.
- Scale check: DATA_W=64, ADDR_W=6, NUM_RD=4, NUM_WR=2: init sweep is 64 cycles, and all 4 read ports independently bypass and read back random writes against a reference model.
